// File: rtl/vl_cfg_unit.sv
// Vector length/type configuration unit: executes vsetvl-style requests and
// tracks in-flight vector ops so a new vl only commits once the lanes drain.
module vl_cfg_unit #(
  parameter int unsigned MVL      = 16,
  parameter int unsigned ELEN     = 32,
  parameter int unsigned INFLIGHT = 8,
  parameter int unsigned AVLW     = 32,
  localparam int unsigned VLW     = $clog2(MVL * 8 * ELEN / 8) + 1,
  localparam int unsigned CW      = $clog2(INFLIGHT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_mode,
  input  logic [AVLW-1:0] req_avl,
  input  logic [2:0]      req_sew,
  input  logic [1:0]      req_lmul,
  output logic            resp_valid,
  output logic [VLW-1:0]  resp_vl,
  output logic [VLW-1:0]  vl,
  output logic [2:0]      vtype_sew,
  output logic [1:0]      vtype_lmul,
  output logic            vill,
  input  logic            issue,
  output logic            issue_ready,
  input  logic            retire,
  output logic [CW-1:0]   inflight,
  output logic            err
);

  localparam logic [2:0] SewReset = (ELEN >= 64) ? 3'd3 :
                                    (ELEN >= 32) ? 3'd2 :
                                    (ELEN >= 16) ? 3'd1 : 3'd0;

  typedef enum logic [1:0] {StIdle, StDrain, StCommit} state_e;

  state_e state_q, state_d;

  logic [1:0]      mode_q;
  logic [AVLW-1:0] avl_q;
  logic [2:0]      sew_q;
  logic [1:0]      lmul_q;

  logic [VLW-1:0]  vl_q;
  logic [2:0]      vsew_q;
  logic [1:0]      vlmul_q;
  logic            vill_q;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic            err_q, err_d;

  logic            accept;
  logic            issue_ok;
  logic            legal;
  logic [VLW-1:0]  vlmax;
  logic [VLW-1:0]  new_vl;
  logic [2:0]      new_sew;
  logic [1:0]      new_lmul;
  logic            new_vill;

  assign accept      = req_valid && (state_q == StIdle);
  assign req_ready   = (state_q == StIdle);
  assign issue_ready = (state_q == StIdle) && !req_valid && (inflight_q < CW'(INFLIGHT));
  assign issue_ok    = issue && issue_ready;
  assign resp_valid  = (state_q == StCommit);
  assign resp_vl     = new_vl;

  assign vl         = vl_q;
  assign vtype_sew  = vsew_q;
  assign vtype_lmul = vlmul_q;
  assign vill       = vill_q;
  assign inflight   = inflight_q;
  assign err        = err_q;

  // Result is derived from the latched request, so it is stable through DRAIN.
  assign legal = (sew_q <= 3'd3) && ((32'd8 << sew_q) <= ELEN) && (mode_q != 2'd3);
  assign vlmax = VLW'((MVL * (ELEN >> (32'd3 + 32'(sew_q)))) << lmul_q);

  always_comb begin
    new_vl   = '0;
    new_sew  = '0;
    new_lmul = '0;
    new_vill = 1'b1;
    if (legal) begin
      new_vill = 1'b0;
      new_sew  = sew_q;
      new_lmul = lmul_q;
      case (mode_q)
        2'd0: new_vl = (avl_q >= AVLW'(vlmax)) ? vlmax : avl_q[VLW-1:0];
        2'd1: new_vl = vlmax;
        default: begin
          // Keep-vl mode: a vl that no longer fits the new vtype is illegal.
          if (vl_q <= vlmax) begin
            new_vl = vl_q;
          end else begin
            new_vill = 1'b1;
            new_sew  = '0;
            new_lmul = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = (inflight_q == '0) ? StCommit : StDrain;
        end
      end
      StDrain: begin
        if (inflight_q == '0) begin
          state_d = StCommit;
        end
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    if (issue_ok && !retire) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!issue_ok && retire) begin
      if (inflight_q == '0) begin
        err_d = 1'b1;
      end else begin
        inflight_d = inflight_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= '0;
      avl_q      <= '0;
      sew_q      <= '0;
      lmul_q     <= '0;
      vl_q       <= VLW'(MVL);
      vsew_q     <= SewReset;
      vlmul_q    <= '0;
      vill_q     <= 1'b0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      if (accept) begin
        mode_q <= req_mode;
        avl_q  <= req_avl;
        sew_q  <= req_sew;
        lmul_q <= req_lmul;
      end
      if (state_q == StCommit) begin
        vl_q    <= new_vl;
        vsew_q  <= new_sew;
        vlmul_q <= new_lmul;
        vill_q  <= new_vill;
      end
    end
  end

endmodule
